bit_reorder_stream: RTL

- Streaming reorder buffer for the FFT/IFFT datapath.
- Accepts one complex sample per cycle, arriving in bit-reversed index order as the FFT butterfly network produces it.
- Emits each N-sample frame in natural index order.
- Uses a ping-pong (two-bank) memory, so one bank fills while the other drains and a continuous stream runs at 1 sample/cycle.

---
 rtl/bit_reorder_stream.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bit_reorder_stream.sv
// Ping-pong reorder buffer: bit-reversed-order input frames are emitted in natural order.
// Optional frame counter output enabled by defining BITREV_FRAME_CNT_EN.
module bit_reorder_stream #(
    parameter int N      = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef BITREV_FRAME_CNT_EN
    output logic [15:0]       frame_count,
`endif
    output logic              out_last
);

    localparam int            AW       = $clog2(N);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] k);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = k[AW-1-i];
        end
        return r;
    endfunction

    logic [DATA_W-1:0] mem_q [2][N];

    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [AW-1:0]     wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [1:0]        full_q, full_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              wr_fire;
    logic              rd_load;

    // in_ready depends only on registered state, never on out_ready
    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    always_comb begin
        wr_fire     = in_valid && in_ready;
        rd_load     = full_q[rd_bank_q] && (!out_valid_q || out_ready);
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        full_d      = full_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + AW'(1);
            if (wr_cnt_q == LAST_IDX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        // The bank being read is always full and the bank being written never is,
        // so the set and clear of full_d below can never target the same bank.
        if (rd_load) begin
            out_data_d  = mem_q[rd_bank_q][rd_cnt_q];
            out_last_d  = (rd_cnt_q == LAST_IDX);
            out_valid_d = 1'b1;
            rd_cnt_d    = rd_cnt_q + AW'(1);
            if (rd_cnt_q == LAST_IDX) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            full_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Sample storage needs no reset; the full flags guard every read.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][bitrev(wr_cnt_q)] <= in_data;
        end
    end

`ifdef BITREV_FRAME_CNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    assign frame_count = frame_count_q;

    always_comb begin
        frame_count_d = frame_count_q;
        if (out_valid_q && out_ready && out_last_q) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end
`endif

endmodule
